// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared by the memory master and the memory model.
// Holds the master FSM state encoding, the memory size in words, the default
// strobe length and the width of the wait counter.
package mem_pkg;

    // Number of addressable memory words.
    localparam int ADDR_LIMIT        = 512;
    // Default number of cycles a read/write strobe is held (legal 1..15).
    localparam int ACCESS_CYCLES_DEF = 2;
    // Wait counter width: enough for ACCESS_CYCLES-1 up to 14.
    localparam int CNT_W             = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: loadable down-counter that times the memory strobe.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset, forces count to 0
//   load     - load count with load_val (has priority over dec)
//   load_val - value to load
//   dec      - decrement count by one
//   count    - current count
//   zero     - high when count is 0
module mem_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (dec)
            count_d = count_q - W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/mem_master.sv
// mem_master: sequences single load/store requests from a control unit onto
// a simple synchronous memory with combinational read data.
// A request is accepted in IDLE, the strobe is held for ACCESS_CYCLES cycles
// in ACCESS, and a one-cycle response is given in DONE. Out-of-range
// addresses skip ACCESS and respond with rsp_err.
// Ports:
//   clock, clear                - clock and synchronous active-high reset
//   req_valid/write/addr/wdata  - request from the control unit
//   req_ready                   - high in IDLE only
//   rsp_valid/data/err          - one-cycle completion with load data / error
//   mem_address, mem_data_in    - memory address and write data (registered)
//   mem_read, mem_write         - memory strobes
//   mem_data_out                - combinational read data from memory
module mem_master
    import mem_pkg::*;
#(
    parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF,
    parameter int ADDR_LIMIT_P  = ADDR_LIMIT
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_data_out
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_CYCLES - 1);

    mem_state_e  state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        wr_q, err_q;
    logic        in_range, accept_ok, accept_err;
    logic        cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt;

    assign in_range   = (req_addr < 32'(ADDR_LIMIT_P));
    assign accept_ok  = (state_q == ST_IDLE) && req_valid && in_range;
    assign accept_err = (state_q == ST_IDLE) && req_valid && !in_range;

    // Counter runs only while a strobe is up; it sits at 0 otherwise.
    assign cnt_load = accept_ok;
    assign cnt_dec  = (state_q == ST_ACCESS) && !cnt_zero;

    mem_wait_counter #(.W(CNT_W)) u_wait (
        .clk      (clock),
        .rst      (clear),
        .load     (cnt_load),
        .load_val (CNT_INIT),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // State register
    always_ff @(posedge clock) begin
        if (clear)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_ok)
                    state_d = ST_ACCESS;
                else if (accept_err)
                    state_d = ST_DONE;
            end
            ST_ACCESS: if (cnt_zero) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state_q)
            ST_IDLE:   req_ready = 1'b1;
            ST_ACCESS: begin
                mem_read  = !wr_q;
                mem_write = wr_q;
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                // Data only for a successful load.
                if (!err_q && !wr_q)
                    rsp_data = rdata_q;
            end
            default: ;
        endcase
    end

    // Request latches and read-data capture. An error request leaves the
    // latched address/data untouched so mem_address does not move.
    always_ff @(posedge clock) begin
        if (clear) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept_ok) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wr_q    <= req_write;
                err_q   <= 1'b0;
            end else if (accept_err) begin
                err_q   <= 1'b1;
            end
            if ((state_q == ST_ACCESS) && cnt_zero && !wr_q)
                rdata_q <= mem_data_out;
        end
    end

    assign mem_address = addr_q;
    assign mem_data_in = wdata_q;

endmodule
